bmp_unpack: RTL and testbench

BMP_UNPACK -- requirements
Module: bmp_unpack

---
 rtl/bmp_unpack.sv | 187 ++++++++++++++++++
 tb/tb_bmp_unpack.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bmp_unpack.sv
// BMP reader: parses a 24-bit BMP header, then copies pixel rows bottom-up into a
// top-down, unpadded raw frame, one byte per two-cycle ADDR/DATA memory access.
module bmp_unpack #(
   parameter int unsigned HDR_BYTES = 54,
   parameter int unsigned RAW_BASE  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   output logic        err,
   output logic [23:0] readAddr,
   input  logic [15:0] readdata,
   output logic [23:0] writeAddr,
   output logic [15:0] wrdata,
   output logic        wren,
   output logic [10:0] imgWidth,
   output logic [10:0] imgHeight
);

   typedef enum logic [2:0] {StIdle, StHdr, StCheck, StPix, StDone} state_e;

   state_e      state_q, state_d;
   logic        phase_q, phase_d;        // 0: ADDR cycle, 1: DATA cycle
   logic [2:0]  hdr_idx_q, hdr_idx_d;
   logic [7:0]  b0_q, b0_d, b1_q, b1_d, bpp_q, bpp_d;
   logic [15:0] w_q, w_d, h_q, h_d;
   logic        err_q, err_d;
   logic [23:0] rd_addr_q, rd_addr_d;
   logic [23:0] wr_addr_q, wr_addr_d;
   logic [23:0] row_base_q, row_base_d;
   logic [12:0] col_q, col_d;
   logic [10:0] rows_left_q, rows_left_d;

   logic [12:0] row_len, stride;
   logic [23:0] first_base;
   logic        hdr_bad;
   logic        unused_hi;

   function automatic logic [23:0] hdr_off(input logic [2:0] idx);
      case (idx)
         3'd0:    hdr_off = 24'd0;
         3'd1:    hdr_off = 24'd1;
         3'd2:    hdr_off = 24'd18;
         3'd3:    hdr_off = 24'd19;
         3'd4:    hdr_off = 24'd22;
         3'd5:    hdr_off = 24'd23;
         default: hdr_off = 24'd28;
      endcase
   endfunction

   assign unused_hi  = ^readdata[15:8];
   assign row_len    = {2'b00, w_q[10:0]} * 13'd3;
   assign stride     = (row_len + 13'd3) & ~13'd3;
   // Bottom BMP row holds the top raw row.
   assign first_base = 24'(HDR_BYTES) + 24'(h_q[10:0] - 11'd1) * 24'(stride);
   assign hdr_bad    = (b0_q != 8'h42) || (b1_q != 8'h4D) || (bpp_q != 8'd24) ||
                       (w_q[10:0] == 11'd0) || (h_q[10:0] == 11'd0) ||
                       (|w_q[15:11]) || (|h_q[15:11]);

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      hdr_idx_d   = hdr_idx_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      bpp_d       = bpp_q;
      w_d         = w_q;
      h_d         = h_q;
      err_d       = err_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      row_base_d  = row_base_q;
      col_d       = col_q;
      rows_left_d = rows_left_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StHdr;
               phase_d   = 1'b0;
               hdr_idx_d = 3'd0;
               rd_addr_d = hdr_off(3'd0);
               wr_addr_d = 24'(RAW_BASE);
               err_d     = 1'b0;
            end
         end
         StHdr: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               case (hdr_idx_q)
                  3'd0:    b0_d       = readdata[7:0];
                  3'd1:    b1_d       = readdata[7:0];
                  3'd2:    w_d[7:0]   = readdata[7:0];
                  3'd3:    w_d[15:8]  = readdata[7:0];
                  3'd4:    h_d[7:0]   = readdata[7:0];
                  3'd5:    h_d[15:8]  = readdata[7:0];
                  default: bpp_d      = readdata[7:0];
               endcase
               if (hdr_idx_q == 3'd6) begin
                  state_d = StCheck;
               end else begin
                  hdr_idx_d = hdr_idx_q + 3'd1;
                  rd_addr_d = hdr_off(hdr_idx_q + 3'd1);
               end
            end
         end
         StCheck: begin
            if (hdr_bad) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               state_d     = StPix;
               phase_d     = 1'b0;
               row_base_d  = first_base;
               rd_addr_d   = first_base;
               col_d       = 13'd0;
               rows_left_d = h_q[10:0];
            end
         end
         StPix: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               wr_addr_d = wr_addr_q + 24'd1;
               if (col_q == row_len - 13'd1) begin
                  col_d = 13'd0;
                  if (rows_left_q == 11'd1) begin
                     state_d = StDone;
                  end else begin
                     // Step up one BMP row; padding tail is skipped entirely.
                     rows_left_d = rows_left_q - 11'd1;
                     row_base_d  = row_base_q - 24'(stride);
                     rd_addr_d   = row_base_q - 24'(stride);
                  end
               end else begin
                  col_d     = col_q + 13'd1;
                  rd_addr_d = rd_addr_q + 24'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         phase_q     <= 1'b0;
         hdr_idx_q   <= 3'd0;
         b0_q        <= 8'd0;
         b1_q        <= 8'd0;
         bpp_q       <= 8'd0;
         w_q         <= 16'd0;
         h_q         <= 16'd0;
         err_q       <= 1'b0;
         rd_addr_q   <= 24'd0;
         wr_addr_q   <= 24'(RAW_BASE);
         row_base_q  <= 24'd0;
         col_q       <= 13'd0;
         rows_left_q <= 11'd0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         hdr_idx_q   <= hdr_idx_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         bpp_q       <= bpp_d;
         w_q         <= w_d;
         h_q         <= h_d;
         err_q       <= err_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         row_base_q  <= row_base_d;
         col_q       <= col_d;
         rows_left_q <= rows_left_d;
      end
   end

   assign done      = (state_q == StDone);
   assign err       = done && err_q;
   assign wren      = (state_q == StPix) && phase_q;
   assign wrdata    = wren ? {8'h00, readdata[7:0]} : 16'h0000;
   assign readAddr  = rd_addr_q;
   assign writeAddr = wr_addr_q;
   assign imgWidth  = w_q[10:0];
   assign imgHeight = h_q[10:0];

endmodule

// File: tb/tb_bmp_unpack.sv
// Directed bench for bmp_unpack: a byte memory model feeds the reader and a queue-based
// model of the raw frame is compared against every write, plus done timing and errors.
module tb_bmp_unpack;
   localparam int HDR = 54;
   localparam int RB  = 0;

   logic        clk = 1'b0;
   logic        rst, start;
   logic        done, err, wren;
   logic [23:0] readAddr, writeAddr;
   logic [15:0] readdata, wrdata;
   logic [10:0] imgWidth, imgHeight;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:127];
   int img_w, img_h;
   logic [7:0] act_data[$];
   int act_addr[$];

   bmp_unpack #(.HDR_BYTES(HDR), .RAW_BASE(RB)) dut (
      .clk(clk), .rst(rst), .start(start), .done(done), .err(err),
      .readAddr(readAddr), .readdata(readdata), .writeAddr(writeAddr),
      .wrdata(wrdata), .wren(wren), .imgWidth(imgWidth), .imgHeight(imgHeight)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data for an address appears one cycle later; junk in the high byte.
   always @(posedge clk) readdata <= {8'hA5, mem[readAddr[6:0]]};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_img(input logic [7:0] b1, input logic [15:0] w16, input logic [15:0] h16,
                          input logic [7:0] bpp);
      for (int i = 0; i < 128; i++) mem[i] = 8'(i);
      mem[0]  = 8'h42;
      mem[1]  = b1;
      mem[18] = w16[7:0];
      mem[19] = w16[15:8];
      mem[22] = h16[7:0];
      mem[23] = h16[15:8];
      mem[28] = bpp;
      img_w   = int'(w16[10:0]);
      img_h   = int'(h16[10:0]);
   endtask

   task automatic run(input bit exp_err, input bit hold);
      logic [7:0] exp_q[$];
      int s, nexp, exp_done, cyc, wi, ra;
      bit got, is_pad;
      s = (3 * img_w + 3) & ~3;
      if (!exp_err)
         for (int y = 0; y < img_h; y++)
            for (int x = 0; x < 3 * img_w; x++)
               exp_q.push_back(mem[(HDR + (img_h - 1 - y) * s + x) & 127]);
      nexp     = exp_q.size();
      exp_done = 16 + 2 * nexp;
      act_data.delete();
      act_addr.delete();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = hold;
      cyc = 0;
      wi  = 0;
      got = 1'b0;
      while (!got && cyc < exp_done + 8) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("done_clear", {31'd0, done}, 0);
         if (!done) chk("err_low", {31'd0, err}, 0);
         if (!exp_err) begin
            ra     = int'(readAddr);
            is_pad = (ra >= HDR) && (ra < HDR + img_h * s) && (((ra - HDR) % s) >= 3 * img_w);
            chk("pad_read", {31'd0, is_pad}, 0);
         end
         if (wren) begin
            if (wi < nexp) begin
               chk("wr_data", {16'd0, wrdata}, {24'd0, exp_q[wi]});
               chk("wr_addr", {8'd0, writeAddr}, RB + wi);
               chk("wr_cycle", cyc, 17 + 2 * wi);
            end else begin
               chk("extra_write", wi, nexp);
            end
            act_data.push_back(wrdata[7:0]);
            act_addr.push_back(int'(writeAddr));
            wi++;
         end
         if (done) begin
            got   = 1'b1;
            start = 1'b0;
            chk("done_cycle", cyc, exp_done);
            chk("err_flag", {31'd0, err}, {31'd0, exp_err});
         end
      end
      start = 1'b0;
      chk("done_seen", {31'd0, got}, 1);
      chk("write_count", wi, nexp);
      if (!exp_err) begin
         chk("img_width", {21'd0, imgWidth}, img_w);
         chk("img_height", {21'd0, imgHeight}, img_h);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_err"}, {31'd0, err}, 0);
      chk({tag, "_wren"}, {31'd0, wren}, 0);
      chk({tag, "_wrdata"}, {16'd0, wrdata}, 0);
      chk({tag, "_raddr"}, {8'd0, readAddr}, 0);
      chk({tag, "_waddr"}, {8'd0, writeAddr}, RB);
      chk({tag, "_w"}, {21'd0, imgWidth}, 0);
      chk({tag, "_h"}, {21'd0, imgHeight}, 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      set_img(8'h4D, 16'd2, 16'd2, 8'd24);
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst = 1'b0;

      // Reset wins over start while idle.
      @(negedge clk) begin rst = 1'b1; start = 1'b1; end
      @(negedge clk) begin rst = 1'b0; start = 1'b0; end
      repeat (5) @(negedge clk);
      chk("prio_idle_raddr", {8'd0, readAddr}, 0);

      // 2x2, stride 8: top raw row comes from BMP row at 62.
      set_img(8'h4D, 16'd2, 16'd2, 8'd24);
      run(1'b0, 1'b0);
      chk("lit_2x2_n", act_data.size(), 12);
      chk("lit_2x2_d0", {24'd0, act_data[0]}, 62);
      chk("lit_2x2_d5", {24'd0, act_data[5]}, 67);
      chk("lit_2x2_d6", {24'd0, act_data[6]}, 54);
      chk("lit_2x2_d11", {24'd0, act_data[11]}, 59);
      chk("lit_2x2_a11", act_addr[11], 11);

      // Restart straight from DONE: identical sequence and timing.
      run(1'b0, 1'b0);
      chk("lit_again_d0", {24'd0, act_data[0]}, 62);

      // 4x1, no padding; start held high throughout must be ignored.
      set_img(8'h4D, 16'd4, 16'd1, 8'd24);
      run(1'b0, 1'b1);
      chk("lit_4x1_d0", {24'd0, act_data[0]}, 54);
      chk("lit_4x1_d11", {24'd0, act_data[11]}, 65);

      set_img(8'h58, 16'd2, 16'd2, 8'd24);
      run(1'b1, 1'b0);
      set_img(8'h4D, 16'd2, 16'd2, 8'd32);
      run(1'b1, 1'b0);
      set_img(8'h4D, 16'd0, 16'd2, 8'd24);
      run(1'b1, 1'b0);
      set_img(8'h4D, 16'h0802, 16'd2, 8'd24);
      run(1'b1, 1'b0);

      // Reset wins over start in DONE.
      @(negedge clk) begin rst = 1'b1; start = 1'b1; end
      @(negedge clk) begin rst = 1'b0; start = 1'b0; end
      chk("prio_done_done", {31'd0, done}, 0);
      repeat (5) @(negedge clk);
      chk("prio_done_raddr", {8'd0, readAddr}, 0);

      // Abort during the 5th pixel write (cycle 25), then decode again.
      set_img(8'h4D, 16'd2, 16'd2, 8'd24);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 25; c++) @(negedge clk);
      chk("abort_wr5", {31'd0, wren}, 1);
      chk("abort_wr5_addr", {8'd0, writeAddr}, RB + 4);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("abort");
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("abort_quiet", {31'd0, wren | done}, 0);
      end
      run(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
